led_seq_ctrl: RTL



---
 rtl/led_seq_ctrl_if.sv | 22 ++
 rtl/led_seq_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/led_seq_ctrl_if.sv
// Command channel for led_seq_ctrl: valid/ready handshake carrying mode, pattern, count and level.
interface led_seq_ctrl_if #(
  parameter int unsigned N_LED    = 4,
  parameter int unsigned PWM_BITS = 4
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_mode;
  logic [N_LED-1:0]    cmd_pattern;
  logic [7:0]          cmd_count;
  logic [PWM_BITS-1:0] cmd_level;

  modport master (
    output cmd_valid, cmd_mode, cmd_pattern, cmd_count, cmd_level,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_pattern, cmd_count, cmd_level,
    output cmd_ready
  );
endinterface

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: OFF/STATIC/BLINK/SHIFT at a divided tick rate, with done on finite runs.
// Optional brightness gating is built when LED_PWM_EN is defined.
module led_seq_ctrl #(
  parameter int unsigned N_LED    = 4,
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  led_seq_ctrl_if.slave    cmd,
  output logic [N_LED-1:0] ledout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_STATIC = 2'd1,
    ST_BLINK  = 2'd2,
    ST_SHIFT  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [N_LED-1:0] pat_q, pat_d;
  logic [N_LED-1:0] stage_q, stage_d;
  logic [N_LED-1:0] led_q, led_d;
  logic [7:0]       count_q, count_d;
  logic [7:0]       tick_cnt_q, tick_cnt_d;
  logic [7:0]       tick_next;
  logic [DIV_W-1:0] div_q, div_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic             tick;

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [PWM_BITS-1:0] level_q, level_d;
`else
  logic unused_level;
  assign unused_level = ^cmd.cmd_level;
`endif

  assign accept = cmd.cmd_valid && ready_q;
  assign tick   = (div_q == DIV_LAST);

  // Next-state: an accepted command always wins over a coincident tick.
  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    stage_d    = stage_q;
    count_d    = count_q;
    tick_cnt_d = tick_cnt_q;
    tick_next  = (tick_cnt_q == 8'hFF) ? tick_cnt_q : tick_cnt_q + 8'(1);
    div_d      = tick ? '0 : div_q + DIV_W'(1);
    ready_d    = !accept;
    done_d     = 1'b0;

    if (accept) begin
      state_d    = state_e'(cmd.cmd_mode);
      pat_d      = cmd.cmd_pattern;
      stage_d    = (cmd.cmd_mode == 2'd0) ? '0 : cmd.cmd_pattern;
      count_d    = cmd.cmd_count;
      tick_cnt_d = '0;
      div_d      = '0;
    end else if (tick && (state_q == ST_BLINK || state_q == ST_SHIFT)) begin
      tick_cnt_d = tick_next;
      if (count_q != 8'd0 && tick_next == count_q) begin
        state_d = ST_OFF;
        stage_d = '0;
        done_d  = 1'b1;
      end else if (state_q == ST_BLINK) begin
        stage_d = (stage_q == '0) ? pat_q : '0;
      end else begin
        stage_d = {stage_q[N_LED-2:0], stage_q[N_LED-1]};
      end
    end

    busy_d = (state_d != ST_OFF);

`ifdef LED_PWM_EN
    // Gate against the counter value that will be live while this output is visible.
    pwm_d   = pwm_q + PWM_BITS'(1);
    level_d = accept ? cmd.cmd_level : level_q;
    led_d   = stage_d & {N_LED{pwm_d < level_d}};
`else
    led_d   = stage_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_OFF;
      pat_q      <= '0;
      stage_q    <= '0;
      led_q      <= '0;
      count_q    <= '0;
      tick_cnt_q <= '0;
      div_q      <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef LED_PWM_EN
      pwm_q      <= '0;
      level_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      stage_q    <= stage_d;
      led_q      <= led_d;
      count_q    <= count_d;
      tick_cnt_q <= tick_cnt_d;
      div_q      <= div_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef LED_PWM_EN
      pwm_q      <= pwm_d;
      level_q    <= level_d;
`endif
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign ledout        = led_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
